branch_redirect_ctrl: RTL and testbench
=======================================

// Module: branch_redirect_ctrl
// PURPOSE
//   Resolves conditional/unconditional branches for the pipelined Mini-RISC and sequences the fetch redirect.
//   Accepts one decoded branch per handshake from ID/EX, evaluates the condition, and computes the target.
//   Taken branches: drives a redirect request to IF, then flushes wrong-path slots. Not-taken: releases immediately.
// PARAMETERS
//   AW            32  PC width (word address)
//   OFFS_W        26  branch offset width, sign-extended to AW
//   PC_STEP        1  PC increment per instruction; target = br_pc + PC_STEP + sext(br_offset), mod 2^AW
//   FLUSH_CYCLES   2  cycles flush is held after redirect accept (0 = no flush)
//   CNT_W         32  statistics counter width (BRANCH_STATS_EN only)
// PORTS
//   clk             in   1       rising-edge clock; single clock domain
//   rst             in   1       synchronous, active-high reset
//   br_valid        in   1       ID/EX presents a candidate instruction
//   br_ready        out  1       controller can accept (IDLE only)
//   br_opcode       in   6       opcode of presented instruction
//   br_rs_data      in   32      rs operand (two's complement)
//   br_pc           in   AW      PC of the branch
//   br_offset       in   OFFS_W  signed word offset
//   redirect_valid  out  1       redirect request to IF
//   redirect_ready  in   1       IF accepts redirect
//   redirect_pc     out  AW      target PC, stable while redirect_valid
//   stall_fetch     out  1       IF must not advance (EVAL, REDIRECT)
//   flush           out  1       squash IF/ID wrong-path contents
//   stat_branches   out  CNT_W   branches resolved (BRANCH_STATS_EN only)
//   stat_taken      out  CNT_W   branches taken (BRANCH_STATS_EN only)
// BEHAVIOUR
//   Opcodes: BZ 6'b100000 (rs==0), BMI 6'b100001 (rs[31]), BPL 6'b100010 (rs>0), BR 6'b100011 (always).
//   Reset: state IDLE; br_ready, redirect_valid, stall_fetch, flush = 0 while rst high; redirect_pc = 0; counters = 0.
//   States: IDLE, EVAL, REDIRECT, FLUSH. All outputs decode from registered state/data.
//   IDLE: br_ready=1. br_valid & branch opcode -> latch opcode/rs/pc/offset, go EVAL.
//     br_valid & non-branch opcode -> consumed, no effect, stay IDLE.
//   EVAL (exactly 1 cycle): stall_fetch=1, br_ready=0. Condition uses latched values.
//     Taken -> register redirect_pc and go REDIRECT. Not taken -> IDLE.
//   REDIRECT: redirect_valid=1, stall_fetch=1. redirect_pc held until redirect_ready.
//     Handshake -> FLUSH if FLUSH_CYCLES>0, else IDLE.
//   FLUSH: flush=1 for exactly FLUSH_CYCLES cycles via down-counter; stall_fetch=0; then IDLE.
//   Latency: accept at cycle N -> redirect_valid at N+2 -> flush starting the cycle after the handshake.
//     Not-taken branch: next accept no earlier than N+2.
//   Target arithmetic wraps modulo 2^AW; no overflow flag.
//   rst mid-operation: pending redirect/flush abandoned; nothing issued after reset; counters cleared.
//   redirect_ready high outside REDIRECT: ignored.
// CONFIGURATION
//   BRANCH_STATS_EN defined: stat_branches +1 per resolved branch (EVAL exit); stat_taken +1 per taken branch.
//     Both counters saturate at all-ones.
//   BRANCH_STATS_EN undefined: stat ports and counters absent; all other behaviour identical.
// STRUCTURE
//   Shared package mini_risc_pkg: opcode localparams (OP_BZ, OP_BMI, OP_BPL, OP_BR) and state enum encoding.
//   One sub-module: branch_comparator (existing condition evaluator), fed from latched opcode/rs.
//   FSM, target adder, flush counter and stats stay in this module.
// TESTING
//   BZ, rs=0, pc=0x100, off=+4 -> taken; redirect_pc=0x105 two cycles after accept; flush high 2 cycles.
//   BPL, rs=0 -> not taken; no redirect_valid/flush; br_ready high again 2 cycles after accept.
//   BMI, rs=0x80000000, off=-3 (26-bit), pc=0x10 -> redirect_pc=0x0E;
//     redirect_ready held low 5 cycles -> redirect_pc stable throughout.
//   BR, pc=0xFFFFFFFF, off=0 -> redirect_pc=0x00000000 (wrap).
//   rst asserted in REDIRECT -> next cycle all outputs 0, state IDLE, no flush pulse.
//   BRANCH_STATS_EN: 3 BZ (rs=0,5,0) -> stat_branches=3, stat_taken=2; non-branch opcode adds nothing.

Source files
------------

// File: rtl/mini_risc_pkg.sv
// Shared Mini-RISC definitions: branch opcodes and the redirect controller state encoding.
package mini_risc_pkg;

  localparam logic [5:0] OP_BZ  = 6'b100000;
  localparam logic [5:0] OP_BMI = 6'b100001;
  localparam logic [5:0] OP_BPL = 6'b100010;
  localparam logic [5:0] OP_BR  = 6'b100011;

  typedef enum logic [1:0] {
    StIdle,
    StEval,
    StRedirect,
    StFlush
  } br_state_e;

  function automatic logic is_branch(logic [5:0] op);
    return (op == OP_BZ) || (op == OP_BMI) || (op == OP_BPL) || (op == OP_BR);
  endfunction

endpackage

// File: rtl/branch_comparator.sv
// Branch condition evaluator: decides taken/not-taken from opcode and the rs operand.
module branch_comparator
  import mini_risc_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [31:0] rs_data,
  output logic        taken
);

  always_comb begin
    taken = 1'b0;
    unique case (opcode)
      OP_BZ:   taken = (rs_data == 32'd0);
      OP_BMI:  taken = rs_data[31];
      // Signed strictly-positive: sign clear and non-zero.
      OP_BPL:  taken = !rs_data[31] && (rs_data != 32'd0);
      OP_BR:   taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Resolves Mini-RISC branches and sequences the IF redirect and wrong-path flush.
// Optional statistics counters are built when BRANCH_STATS_EN is defined.
module branch_redirect_ctrl
  import mini_risc_pkg::*;
#(
  parameter int unsigned AW           = 32,
  parameter int unsigned OFFS_W       = 26,
  parameter int unsigned PC_STEP      = 1,
  parameter int unsigned FLUSH_CYCLES = 2
`ifdef BRANCH_STATS_EN
  ,
  parameter int unsigned CNT_W        = 32
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [5:0]        br_opcode,
  input  logic [31:0]       br_rs_data,
  input  logic [AW-1:0]     br_pc,
  input  logic [OFFS_W-1:0] br_offset,
  output logic              redirect_valid,
  input  logic              redirect_ready,
  output logic [AW-1:0]     redirect_pc,
  output logic              stall_fetch,
  output logic              flush
`ifdef BRANCH_STATS_EN
  ,
  output logic [CNT_W-1:0]  stat_branches,
  output logic [CNT_W-1:0]  stat_taken
`endif
);

  localparam int unsigned FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;

  br_state_e         state_q, state_d;
  logic [5:0]        op_q, op_d;
  logic [31:0]       rs_q, rs_d;
  logic [AW-1:0]     pc_q, pc_d;
  logic [OFFS_W-1:0] off_q, off_d;
  logic [AW-1:0]     redir_pc_q, redir_pc_d;
  logic [FW-1:0]     cnt_q, cnt_d;
  logic              taken;
  logic [AW-1:0]     target;

  branch_comparator u_cmp (
    .opcode  (op_q),
    .rs_data (rs_q),
    .taken   (taken)
  );

  // Sum is truncated to AW bits, so the target wraps modulo 2^AW.
  assign target = pc_q + AW'(PC_STEP) + {{(AW - OFFS_W){off_q[OFFS_W-1]}}, off_q};

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rs_d       = rs_q;
    pc_d       = pc_q;
    off_d      = off_q;
    redir_pc_d = redir_pc_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      StIdle: begin
        // Non-branch opcodes are accepted and dropped.
        if (br_valid && is_branch(br_opcode)) begin
          op_d    = br_opcode;
          rs_d    = br_rs_data;
          pc_d    = br_pc;
          off_d   = br_offset;
          state_d = StEval;
        end
      end
      StEval: begin
        if (taken) begin
          redir_pc_d = target;
          state_d    = StRedirect;
        end else begin
          state_d = StIdle;
        end
      end
      StRedirect: begin
        if (redirect_ready) begin
          if (FLUSH_CYCLES > 0) begin
            cnt_d   = FW'(FLUSH_CYCLES);
            state_d = StFlush;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StFlush: begin
        if (cnt_q <= FW'(1)) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - FW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      op_q       <= '0;
      rs_q       <= '0;
      pc_q       <= '0;
      off_q      <= '0;
      redir_pc_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rs_q       <= rs_d;
      pc_q       <= pc_d;
      off_q      <= off_d;
      redir_pc_q <= redir_pc_d;
      cnt_q      <= cnt_d;
    end
  end

  // Handshake outputs are forced low during reset, before the state register has settled.
  always_comb begin
    br_ready       = !rst && (state_q == StIdle);
    stall_fetch    = !rst && ((state_q == StEval) || (state_q == StRedirect));
    redirect_valid = !rst && (state_q == StRedirect);
    flush          = !rst && (state_q == StFlush);
    redirect_pc    = redir_pc_q;
  end

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] branches_q, taken_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      branches_q <= '0;
      taken_q    <= '0;
    end else if (state_q == StEval) begin
      if (branches_q != '1) begin
        branches_q <= branches_q + CNT_W'(1);
      end
      if (taken && (taken_q != '1)) begin
        taken_q <= taken_q + CNT_W'(1);
      end
    end
  end

  assign stat_branches = branches_q;
  assign stat_taken    = taken_q;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed self-checking bench for branch_redirect_ctrl (stats checks when BRANCH_STATS_EN is defined).
module tb_branch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        br_valid;
  logic        br_ready;
  logic [5:0]  br_opcode;
  logic [31:0] br_rs_data;
  logic [31:0] br_pc;
  logic [25:0] br_offset;
  logic        redirect_valid;
  logic        redirect_ready;
  logic [31:0] redirect_pc;
  logic        stall_fetch;
  logic        flush;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_taken;
`endif

  int total = 0;
  int bad   = 0;

  branch_redirect_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .br_valid       (br_valid),
    .br_ready       (br_ready),
    .br_opcode      (br_opcode),
    .br_rs_data     (br_rs_data),
    .br_pc          (br_pc),
    .br_offset      (br_offset),
    .redirect_valid (redirect_valid),
    .redirect_ready (redirect_ready),
    .redirect_pc    (redirect_pc),
    .stall_fetch    (stall_fetch),
    .flush          (flush)
`ifdef BRANCH_STATS_EN
    ,
    .stat_branches  (stat_branches),
    .stat_taken     (stat_taken)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; land 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [5:0] op, input logic [31:0] rs, input logic [31:0] pc,
                         input logic [25:0] off);
    br_valid   = 1'b1;
    br_opcode  = op;
    br_rs_data = rs;
    br_pc      = pc;
    br_offset  = off;
  endtask

  task automatic check_outs(input string tag, input logic rdy, input logic rv, input logic st,
                            input logic fl);
    check_eq({tag, ".br_ready"}, 64'(br_ready), 64'(rdy));
    check_eq({tag, ".redirect_valid"}, 64'(redirect_valid), 64'(rv));
    check_eq({tag, ".stall_fetch"}, 64'(stall_fetch), 64'(st));
    check_eq({tag, ".flush"}, 64'(flush), 64'(fl));
  endtask

  initial begin
    rst            = 1'b1;
    br_valid       = 1'b0;
    br_opcode      = 6'd0;
    br_rs_data     = 32'd0;
    br_pc          = 32'd0;
    br_offset      = 26'd0;
    redirect_ready = 1'b0;
    cyc();
    cyc();
    check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("reset.redirect_pc", 64'(redirect_pc), 64'h0);
    rst = 1'b0;
    cyc();
    check_outs("idle", 1'b1, 1'b0, 1'b0, 1'b0);

    // BZ rs=0 pc=0x100 off=+4: taken, target 0x105, two flush cycles.
    present(6'b100000, 32'd0, 32'h100, 26'd4);
    redirect_ready = 1'b1;
    cyc();
    br_valid = 1'b0;
    check_outs("bz.eval", 1'b0, 1'b0, 1'b1, 1'b0);
    cyc();
    check_outs("bz.redir", 1'b0, 1'b1, 1'b1, 1'b0);
    check_eq("bz.redirect_pc", 64'(redirect_pc), 64'h105);
    cyc();
    redirect_ready = 1'b0;
    check_outs("bz.flush1", 1'b0, 1'b0, 1'b0, 1'b1);
    cyc();
    check_outs("bz.flush2", 1'b0, 1'b0, 1'b0, 1'b1);
    cyc();
    check_outs("bz.done", 1'b1, 1'b0, 1'b0, 1'b0);

    // BPL rs=0: not taken; stray redirect_ready must be ignored.
    present(6'b100010, 32'd0, 32'h40, 26'd8);
    redirect_ready = 1'b1;
    cyc();
    br_valid = 1'b0;
    check_outs("bpl.eval", 1'b0, 1'b0, 1'b1, 1'b0);
    cyc();
    check_outs("bpl.idle", 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
    check_outs("bpl.after", 1'b1, 1'b0, 1'b0, 1'b0);
    redirect_ready = 1'b0;

    // Non-branch opcode: consumed, nothing happens.
    present(6'b000001, 32'd0, 32'h300, 26'd1);
    cyc();
    br_valid = 1'b0;
    check_outs("nonbr", 1'b1, 1'b0, 1'b0, 1'b0);

    // BMI rs=0x80000000 pc=0x10 off=-3: target 0x0E, held through 5 stalled cycles.
    present(6'b100001, 32'h8000_0000, 32'h10, 26'h3FF_FFFD);
    cyc();
    br_valid = 1'b0;
    cyc();
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("bmi.hold%0d.valid", i), 64'(redirect_valid), 64'h1);
      check_eq($sformatf("bmi.hold%0d.pc", i), 64'(redirect_pc), 64'h0E);
      if (i == 4) redirect_ready = 1'b1;
      cyc();
    end
    redirect_ready = 1'b0;
    check_outs("bmi.flush1", 1'b0, 1'b0, 1'b0, 1'b1);
    cyc();
    cyc();
    check_outs("bmi.done", 1'b1, 1'b0, 1'b0, 1'b0);

    // BR pc=0xFFFFFFFF off=0: target wraps to 0.
    present(6'b100011, 32'h1234, 32'hFFFF_FFFF, 26'd0);
    cyc();
    br_valid = 1'b0;
    cyc();
    check_eq("br.valid", 64'(redirect_valid), 64'h1);
    check_eq("br.wrap_pc", 64'(redirect_pc), 64'h0);
    redirect_ready = 1'b1;
    cyc();
    redirect_ready = 1'b0;
    cyc();
    cyc();
    check_outs("br.done", 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset while in REDIRECT: everything drops, no flush afterwards.
    present(6'b100000, 32'd0, 32'h200, 26'd0);
    cyc();
    br_valid = 1'b0;
    cyc();
    check_eq("rst.pre_pc", 64'(redirect_pc), 64'h201);
    check_eq("rst.pre_valid", 64'(redirect_valid), 64'h1);
    rst = 1'b1;
    redirect_ready = 1'b1;
    cyc();
    check_outs("rst.during", 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("rst.redirect_pc", 64'(redirect_pc), 64'h0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check_outs($sformatf("rst.after%0d", i), 1'b1, 1'b0, 1'b0, 1'b0);
    end
    redirect_ready = 1'b0;

`ifdef BRANCH_STATS_EN
    check_eq("stat.cleared_br", 64'(stat_branches), 64'd0);
    check_eq("stat.cleared_tk", 64'(stat_taken), 64'd0);
    redirect_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      present(6'b100000, (k == 1) ? 32'd5 : 32'd0, 32'h80, 26'd2);
      cyc();
      br_valid = 1'b0;
      for (int w = 0; w < 6; w++) cyc();
    end
    present(6'b000111, 32'd0, 32'h0, 26'd0);
    cyc();
    br_valid = 1'b0;
    cyc();
    check_eq("stat.branches", 64'(stat_branches), 64'd3);
    check_eq("stat.taken", 64'(stat_taken), 64'd2);
    redirect_ready = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
